// File: rtl/add_serial_sched.sv
`timescale 1ns/1ps
// add_serial_sched
// Round-robin scheduler that shares one bit-serial adder among N_REQ requesters.
// It performs one operation at a time: arbitrate, latch the operands, pulse
// add_en, wait ADD_LAT cycles, capture add_out, then hold the result until it is
// accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   req        per-requester request, held high until granted
//   req_a      operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      operand B, same packing
//   gnt        one-hot, one-cycle pulse: that requester's operands are taken
//   add_en     one-cycle start pulse to the adder
//   add_a      registered operand A to the adder
//   add_b      registered operand B to the adder
//   add_out    adder result, sampled on the last WAIT cycle
//   rsp_valid  result available
//   rsp_ready  consumer accepts the result when rsp_valid & rsp_ready
//   rsp_id     index of the requester that owns the result
//   rsp_sum    captured sum (mod 2^WIDTH)
//   busy       high in any state other than IDLE
//
// state  | meaning
// IDLE   | arbitrate; gnt pulses for the winner and its operands are latched
// LAUNCH | add_en high for this one cycle; the wait counter is cleared
// WAIT   | count adder latency; add_out is captured on the last count
// HOLD   | result presented until the rsp_valid/rsp_ready handshake
module add_serial_sched #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int ADD_LAT = 10,
    localparam int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW     = $clog2(ADD_LAT) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       gnt,
    output logic                   add_en,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic [WIDTH-1:0]       add_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IW-1:0]          rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          cnt_done;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;

    assign cnt_done = (cnt == CW'(ADD_LAT - 1));

    // Search starts one past the last winner and wraps, so the first hit is the
    // round-robin winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + 1'b1;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (cnt_done) state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs
    always_comb begin
        gnt       = '0;
        add_en    = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (win_found) gnt[win_idx] = 1'b1;
            LAUNCH:  add_en = 1'b1;
            HOLD:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operands stay registered from the grant until the next grant, so they
    // are stable for the whole of LAUNCH and WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_a   <= '0;
            add_b   <= '0;
            rsp_id  <= '0;
            rsp_sum <= '0;
            cnt     <= '0;
            ptr     <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        add_a  <= req_a[win_idx*WIDTH +: WIDTH];
                        add_b  <= req_b[win_idx*WIDTH +: WIDTH];
                        rsp_id <= win_idx;
                        ptr    <= win_idx;
                    end
                end
                LAUNCH: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt_done) rsp_sum <= add_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_serial_sched.sv
`timescale 1ns/1ps
module tb_add_serial_sched;
    localparam int N_REQ   = 4;
    localparam int WIDTH   = 8;
    localparam int ADD_LAT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  gnt;
    logic        add_en;
    logic [7:0]  add_a, add_b, add_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat_cnt = 0;

    add_serial_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .add_en(add_en), .add_a(add_a), .add_b(add_b),
        .add_out(add_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder model: the sum only becomes valid ADD_LAT cycles after add_en.
    always @(posedge clk) begin
        if (add_en) lat_cnt <= 1;
        else if (lat_cnt > 0 && lat_cnt < 100) lat_cnt <= lat_cnt + 1;
    end
    assign add_out = (lat_cnt >= ADD_LAT) ? 8'(add_a + add_b) : 8'hEE;

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic drive_at_edge();
        @(posedge clk);
        #1;
    endtask

    // returns number of negedges waited (bounded)
    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        @(negedge clk);
        while (gnt === 4'b0000 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0 || add_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            add_a !== 8'h00 || add_b !== 8'h00 || rsp_sum !== 8'h00 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: gnt=%b add_en=%b rsp_valid=%b busy=%b add_a=%h add_b=%h sum=%h id=%0d want all zero",
                     gnt, add_en, rsp_valid, busy, add_a, add_b, rsp_sum, rsp_id);
        end
        drive_at_edge();
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        drive_at_edge();
        set_ops(0, 8'h25, 8'h13);
        rsp_ready = 1'b0;
        req = 4'b0001;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++; $display("FAIL basic_gnt: got %b want 0001", gnt);
        end
        drive_at_edge();
        req = 4'b0000;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000 || add_en !== 1'b1 || add_a !== 8'h25 || add_b !== 8'h13) begin
            bad++;
            $display("FAIL basic_launch: gnt=%b add_en=%b a=%h b=%h want 0000 1 25 13", gnt, add_en, add_a, add_b);
        end
        n = 1;
        while (rsp_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 12) begin
            bad++; $display("FAIL basic_latency: rsp_valid at T+%0d want T+12", n);
        end
        total++;
        if (rsp_id !== 2'd0 || rsp_sum !== 8'h38 || busy !== 1'b1) begin
            bad++; $display("FAIL basic_result: id=%0d sum=%h busy=%b want 0 38 1", rsp_id, rsp_sum, busy);
        end
        drive_at_edge();
        rsp_ready = 1'b1;
        drive_at_edge();
        rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_handshake: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int t_prev;
        int exp_id[5];
        logic [7:0] exp_sum[4];
        logic [3:0] exp_g;
        exp_id = '{0, 1, 2, 3, 0};
        exp_sum = '{8'h11, 8'h22, 8'h33, 8'h44};
        t_prev = 0;
        drive_at_edge();
        rst = 1'b0;
        drive_at_edge();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, 8'(8'h10 * (i + 1)), 8'(i + 1));
        rsp_ready = 1'b1;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(n);
            exp_g = 4'b0001 << exp_id[g];
            total++;
            if (gnt !== exp_g) begin
                bad++; $display("FAIL rr_order[%0d]: gnt=%b want %b", g, gnt, exp_g);
            end
            if (g > 0) begin
                total++;
                if (cyc - t_prev !== 13) begin
                    bad++; $display("FAIL rr_interval[%0d]: %0d cycles want 13", g, cyc - t_prev);
                end
            end
            t_prev = cyc;
            if (g == 4) begin
                drive_at_edge();
                req = 4'b0000;
            end
            wait_valid(n);
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id[g]) || rsp_sum !== exp_sum[exp_id[g]]) begin
                bad++;
                $display("FAIL rr_result[%0d]: valid=%b id=%0d sum=%h want 1 %0d %h",
                         g, rsp_valid, rsp_id, rsp_sum, exp_id[g], exp_sum[exp_id[g]]);
            end
        end
        wait_idle(n);
    endtask

    task automatic test_overflow();
        int n;
        drive_at_edge();
        set_ops(1, 8'hF0, 8'h20);
        rsp_ready = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010) begin
            bad++; $display("FAIL ovf_gnt: got %b want 0010", gnt);
        end
        drive_at_edge();
        req = 4'b0000;
        wait_valid(n);
        total++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'h10 || rsp_id !== 2'd1) begin
            bad++; $display("FAIL ovf_sum: valid=%b sum=%h id=%0d want 1 10 1", rsp_valid, rsp_sum, rsp_id);
        end
        wait_idle(n);
    endtask

    task automatic test_hold();
        int n;
        int errs;
        drive_at_edge();
        rsp_ready = 1'b0;
        set_ops(2, 8'h01, 8'h02);
        req = 4'b0100;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0100) begin
            bad++; $display("FAIL hold_gnt: got %b want 0100", gnt);
        end
        drive_at_edge();
        req = 4'b0000;
        wait_valid(n);
        drive_at_edge();
        req = 4'b0001;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_sum !== 8'h03 || rsp_id !== 2'd2 ||
                gnt !== 4'b0000 || busy !== 1'b1) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL hold_stable: %0d bad cycles want 0 (last valid=%b sum=%h id=%0d gnt=%b busy=%b)",
                            errs, rsp_valid, rsp_sum, rsp_id, gnt, busy);
        end
        drive_at_edge();
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || gnt !== 4'b0000) begin
            bad++; $display("FAIL hold_hs_cycle: valid=%b gnt=%b want 1 0000", rsp_valid, gnt);
        end
        drive_at_edge();
        rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || gnt !== 4'b0001) begin
            bad++; $display("FAIL hold_release: valid=%b gnt=%b want 0 0001", rsp_valid, gnt);
        end
        drive_at_edge();
        req = 4'b0000;
        wait_valid(n);
        drive_at_edge();
        rsp_ready = 1'b1;
        wait_idle(n);
    endtask

    task automatic test_reset_mid();
        int n;
        drive_at_edge();
        rsp_ready = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010) begin
            bad++; $display("FAIL rmid_gnt: got %b want 0010", gnt);
        end
        drive_at_edge();
        req = 4'b0000;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (gnt !== 4'b0 || add_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            add_a !== 8'h00 || add_b !== 8'h00 || rsp_sum !== 8'h00 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL rmid_outputs: gnt=%b add_en=%b valid=%b busy=%b a=%h b=%h sum=%h id=%0d want all zero",
                     gnt, add_en, rsp_valid, busy, add_a, add_b, rsp_sum, rsp_id);
        end
        drive_at_edge();
        rst = 1'b1;
        set_ops(0, 8'h25, 8'h13);
        req = 4'b1001;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++; $display("FAIL rmid_priority: gnt=%b want 0001", gnt);
        end
        drive_at_edge();
        req = 4'b1000;
        wait_valid(n);
        total++;
        if (rsp_id !== 2'd0 || rsp_sum !== 8'h38) begin
            bad++; $display("FAIL rmid_first_rsp: id=%0d sum=%h want 0 38", rsp_id, rsp_sum);
        end
        wait_gnt(n);
        total++;
        if (gnt !== 4'b1000) begin
            bad++; $display("FAIL rmid_second_gnt: gnt=%b want 1000", gnt);
        end
        drive_at_edge();
        req = 4'b0000;
        wait_valid(n);
        wait_idle(n);
    endtask

    task automatic test_drop();
        int n;
        int seen2;
        drive_at_edge();
        rsp_ready = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010) begin
            bad++; $display("FAIL drop_gnt: got %b want 0010", gnt);
        end
        seen2 = 0;
        drive_at_edge();
        req = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) req = 4'b0100;
            if (i == 8) req = 4'b0000;
            @(negedge clk);
            if (gnt[2] === 1'b1) seen2++;
            @(posedge clk);
            #1;
        end
        total++;
        if (seen2 !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL drop_not_served: gnt2 seen %0d times busy=%b want 0 0", seen2, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
